// File: rtl/sgm_path_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sgm_path_sequencer
// Description : Raster-position sequencer for one SGM path cost calculator.
//               It tracks column and row, generates the path_beginning
//               strobe and holds frame-synchronous P1/P2 penalties.
//               Line/frame timing checks are built only when
//               SGM_TIMING_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module sgm_path_sequencer #(
    parameter int IMG_WIDTH  = 1600,
    parameter int IMG_HEIGHT = 1200,
    parameter int PATH_DIR   = 0,
    parameter int P_BITS     = 8,
    parameter int P1_DEFAULT = 10,
    parameter int P2_DEFAULT = 120
) (
    input  logic                          in_clk,
    input  logic                          in_rst_n,
    input  logic                          in_de,
    input  logic                          in_vsync,
    input  logic                          in_cfg_we,
    input  logic [P_BITS-1:0]             in_cfg_P1,
    input  logic [P_BITS-1:0]             in_cfg_P2,
    output logic                          out_de,
    output logic                          out_path_beginning,
    output logic [P_BITS-1:0]             out_P1,
    output logic [P_BITS-1:0]             out_P2,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_x,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_y,
    output logic                          out_frame_end,
    output logic                          out_err
);

    localparam int X_W = $clog2(IMG_WIDTH);
    localparam int Y_W = $clog2(IMG_HEIGHT);

    localparam logic [X_W-1:0] c_x_last = X_W'(IMG_WIDTH - 1);
    localparam logic [Y_W-1:0] c_y_last = Y_W'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_LINE = 2'd1,
        ST_LINE      = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_vsync_q;
    logic [X_W-1:0]      r_x;
    logic [Y_W-1:0]      r_y;
    logic [P_BITS-1:0]   r_pend_p1;
    logic [P_BITS-1:0]   r_pend_p2;

    logic                w_vs_rise;
    logic                w_in_frame;
    logic                w_pix_go;
    logic [X_W-1:0]      w_x_inc;
    logic [X_W-1:0]      w_pix_x;
    logic                w_cond;

    // The vsync-rise cycle restarts the frame, so a pixel on that cycle is dropped.
    assign w_vs_rise  = in_vsync & ~r_vsync_q;
    assign w_in_frame = (r_state == ST_WAIT_LINE) || (r_state == ST_LINE);
    assign w_pix_go   = in_de & w_in_frame & ~w_vs_rise;
    assign w_x_inc    = (r_x == c_x_last) ? r_x : r_x + 1'b1;
    assign w_pix_x    = (r_state == ST_LINE) ? w_x_inc : '0;

    if (PATH_DIR == 1) begin : g_dir_vert
        assign w_cond = (r_y == '0);
    end else if (PATH_DIR == 2) begin : g_dir_diag_dr
        assign w_cond = (w_pix_x == '0) || (r_y == '0);
    end else if (PATH_DIR == 3) begin : g_dir_diag_dl
        assign w_cond = (w_pix_x == c_x_last) || (r_y == '0);
    end else begin : g_dir_horiz
        assign w_cond = (w_pix_x == '0);
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state            <= ST_IDLE;
            r_vsync_q          <= 1'b1;
            r_x                <= '0;
            r_y                <= '0;
            r_pend_p1          <= P_BITS'(P1_DEFAULT);
            r_pend_p2          <= P_BITS'(P2_DEFAULT);
            out_P1             <= P_BITS'(P1_DEFAULT);
            out_P2             <= P_BITS'(P2_DEFAULT);
            out_de             <= 1'b0;
            out_path_beginning <= 1'b0;
            out_x              <= '0;
            out_y              <= '0;
            out_frame_end      <= 1'b0;
        end else begin
            r_vsync_q          <= in_vsync;
            out_frame_end      <= 1'b0;
            out_de             <= w_pix_go;
            out_path_beginning <= w_pix_go & w_cond;

            if (in_cfg_we) begin
                r_pend_p1 <= in_cfg_P1;
                r_pend_p2 <= in_cfg_P2;
            end

            if (w_pix_go) begin
                r_x   <= w_pix_x;
                out_x <= w_pix_x;
                out_y <= r_y;
            end

            if (w_vs_rise) begin
                r_x     <= '0;
                r_y     <= '0;
                out_P1  <= in_cfg_we ? in_cfg_P1 : r_pend_p1;
                out_P2  <= in_cfg_we ? in_cfg_P2 : r_pend_p2;
                r_state <= ST_WAIT_LINE;
            end else begin
                case (r_state)
                    ST_WAIT_LINE: begin
                        if (in_de) begin
                            r_state <= ST_LINE;
                        end
                    end
                    ST_LINE: begin
                        if (!in_de) begin
                            r_x <= '0;
                            if (r_y == c_y_last) begin
                                out_frame_end <= 1'b1;
                                r_state       <= ST_DONE;
                            end else begin
                                r_y     <= r_y + 1'b1;
                                r_state <= ST_WAIT_LINE;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

`ifdef SGM_TIMING_CHECK_EN
    logic r_err;
    logic r_ovf;

    // r_ovf remembers a pixel arriving after x already saturated at the last column.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_err <= 1'b0;
            r_ovf <= 1'b0;
        end else if (w_vs_rise) begin
            r_ovf <= 1'b0;
            if (w_in_frame && ((r_x != '0) || (r_y != '0))) begin
                r_err <= 1'b1;
            end
        end else if (r_state == ST_LINE) begin
            if (in_de) begin
                if (r_x == c_x_last) begin
                    r_ovf <= 1'b1;
                end
            end else begin
                r_ovf <= 1'b0;
                if (r_ovf || (r_x != c_x_last)) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign out_err = r_err;
`else
    assign out_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sgm_path_sequencer.md
# sgm_path_sequencer

Raster-position controller that sequences one `path_cost_calculator` instance from the video timing stream. It tracks column and row, and generates the per-pixel `path_beginning` strobe for a configured SGM path direction. It also holds the P1/P2 penalties in frame-synchronous shadow registers, so penalties never change mid-frame. It sits between the video timing front end and the path cost datapath, one instance per aggregation direction.

## Interface
- `IMG_WIDTH`, 1600: active pixels per line; equals the `PATH_DELAY` of the controlled vertical path.
- `IMG_HEIGHT`, 1200: active lines per frame.
- `PATH_DIR`, 0: 0 = horizontal L→R, 1 = vertical top→bottom, 2 = diagonal down-right, 3 = diagonal down-left.
- `P_BITS`, 8: penalty width.
- `P1_DEFAULT`, 10: reset value of P1.
- `P2_DEFAULT`, 120: reset value of P2.
- `in_clk` input 1: single clock, all logic rising-edge.
- `in_rst_n` input 1: asynchronous, active-low reset.
- `in_de` input 1: active-pixel qualifier.
- `in_vsync` input 1: frame start; the rising edge is significant.
- `in_cfg_we` input 1: write pending penalties.
- `in_cfg_P1` input `P_BITS`: pending P1.
- `in_cfg_P2` input `P_BITS`: pending P2.
- `out_de` output 1: `in_de` delayed one cycle.
- `out_path_beginning` output 1: drives `in_path_beginning`.
- `out_P1` output `P_BITS`: active P1.
- `out_P2` output `P_BITS`: active P2.
- `out_x` output `clog2(IMG_WIDTH)`: column of the current `out_de` pixel.
- `out_y` output `clog2(IMG_HEIGHT)`: row of the current `out_de` pixel.
- `out_frame_end` output 1: one-cycle pulse after the last line.
- `out_err` output 1: sticky timing-error flag.

## Operation
- **Vsync edge detector.** `vsync_q` is reset to 1, so a `vsync` held high out of reset is not treated as an edge. `vs_rise = in_vsync & ~vsync_q`.
- **FSM states:** IDLE, WAIT_LINE, LINE, DONE.
- **IDLE.** Entered on reset. `in_de` is ignored.
- **Any state, `vs_rise` (including mid-line or in DONE):**
  - x = 0, y = 0.
  - Active P1/P2 are loaded from the pending registers.
  - Go to WAIT_LINE.
- **WAIT_LINE, `in_de` = 1:** go to LINE. This pixel is x = 0.
- **LINE, `in_de` = 1:** x increments, saturating at `IMG_WIDTH`-1.
- **LINE, `in_de` = 0 (line end):**
  - x = 0.
  - If y == `IMG_HEIGHT`-1: pulse `frame_end` and go to DONE.
  - Else: y increments and go to WAIT_LINE.
- **DONE.** `in_de` is ignored until `vs_rise`.
- **`in_de` outside WAIT_LINE/LINE:** `out_de` is forced to 0. The datapath never sees pixels outside the frame.
- **Path beginning.** `out_path_beginning = out_de & cond(x, y)`:
  - `PATH_DIR` 0: x == 0.
  - `PATH_DIR` 1: y == 0.
  - `PATH_DIR` 2: x == 0 or y == 0.
  - `PATH_DIR` 3: x == `IMG_WIDTH`-1 or y == 0.
- **Config writes.**
  - `in_cfg_we` writes the pending registers at any time.
  - If `in_cfg_we` and `vs_rise` occur in the same cycle, the new input values go directly to both the pending and active registers.
- **Arithmetic.** Counters are unsigned. Penalties pass through unmodified.

## Timing
- **Reset values:**
  - `out_de`, `out_path_beginning`, `out_frame_end`, `out_err`: 0.
  - `out_x`, `out_y`: 0.
  - `out_P1` = `P1_DEFAULT`, `out_P2` = `P2_DEFAULT`.
  - FSM = IDLE.
- **Pixel outputs.** All outputs are registered. `out_de`, `out_x`, `out_y` and `out_path_beginning` are mutually aligned, with 1-cycle latency from `in_de`.
- **Penalty update.** `out_P1`/`out_P2` change on the cycle after the `in_vsync` rising sample. This is before the first `out_de` of the frame whenever there is at least 1 cycle from the vsync edge to first `in_de`.
- **Frame end.** `out_frame_end` is asserted the cycle after the `in_de` falling sample of line `IMG_HEIGHT`-1, for exactly 1 cycle.
- **Back-to-back lines.** A single de-low cycle between lines is sufficient. No minimum blanking is required.

## Configuration
- `SGM_TIMING_CHECK_EN`, defined:
  - `out_err` is set on any of:
    - a line longer or shorter than `IMG_WIDTH` (checked at line end);
    - `vs_rise` while in WAIT_LINE/LINE with y != 0 or x != 0 (an incomplete frame).
  - `out_err` is cleared only by reset.
- `SGM_TIMING_CHECK_EN`, undefined:
  - `out_err` is tied to 0.
  - The check logic is not synthesized.
  - Functional behaviour is otherwise identical, including x saturation.

## Test plan
- **Reset and first frame.** Stimulus: reset, then vsync pulse, then 2 lines of 1600 de-high cycles, `PATH_DIR`=0. Required: `out_path_beginning` is high only at `out_x`=0 of each line; P1=10, P2=120.
- **Direction 3.** Stimulus: `PATH_DIR`=3, 4×3 image. Required: beginning is high for all of row 0 and at x=3 of rows 1 and 2.
- **Config shadowing.** Stimulus: `cfg_we` with P1=5, P2=200 mid-frame. Required: outputs are unchanged until the next vsync, and update 1 cycle after it. Stimulus: `cfg_we` in the same cycle as the vsync rise. Required: the new values are active for that frame.
- **Frame end.** Stimulus: full 1600×1200 frame, followed by extra de pulses. Required: `out_frame_end` is a single pulse after line 1199, and the extra pulses produce `out_de`=0.
- **Error detection** (`SGM_TIMING_CHECK_EN`). Stimulus: a 1599-pixel line. Required: `out_err` rises and stays high through the next vsync. Stimulus: vsync mid-line. Required: counters restart at 0.
- **Reset mid-line.** Stimulus: assert `in_rst_n`=0 at x=700. Required: all outputs return immediately to reset values, and `in_de` is ignored until the next vsync rise.
